aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller built around a single shared round datapath; one round is evaluated per clock.
- Accepts a key/plaintext pair on a start handshake, runs round 0 (AddRoundKey only), rounds 1..9 (full) and round 10 (no MixColumns), then presents the ciphertext with a one-cycle done pulse.
- Sits between the garbled-circuit I/O wrapper and the round logic. It replaces elaboration-time round selection with a runtime round index.

Parameters:
- NR, 10, number of AES rounds; only 10 (AES-128) is supported, and any other value is an elaboration error.
- DW, 128, state/key width in bits; fixed at 128.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-low.
- start  input  1  request to encrypt; sampled only when ready=1.
- key  input  128  cipher key; byte 0 at bits [127:120].
- msg  input  128  plaintext, same byte order as key.
- ready  output  1  high in IDLE; a start is accepted this cycle.
- busy  output  1  high while rounds are executing (RUN state).
- done  output  1  one-cycle pulse; ct valid this cycle.
- ct  output  128  ciphertext; holds its value until the next accepted start or reset.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FSM goes to IDLE; round counter = 0; state and round-key registers = 0; ct = 0.
  - ready=1, busy=0, done=0 in the cycle after reset.
  - Reset mid-operation abandons the computation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1: state_reg<=msg, rk_reg<=key, rnd<=0, go to RUN.
  - key and msg are sampled only on this edge.
- RUN (busy=1, ready=0), at each edge:
  - state_reg <= round_dp(state_reg, rk_reg, rnd); rk_reg <= next_key(rk_reg, rnd); rnd <= rnd+1.
  - When rnd==NR, go to DONE instead of incrementing. The counter does not wrap; it returns to 0 in IDLE.
- round_dp selection by rnd:
  - rnd==0: x ^ rk.
  - 1..NR-1: MixColumns(ShiftRows(SubBytes(x))) ^ rk.
  - rnd==NR: ShiftRows(SubBytes(x)) ^ rk.
- next_key: standard AES-128 expansion step using Rcon[rnd+1]. Required Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - The round-key register always holds the key for the round indexed by rnd.
- DONE:
  - ct<=state_reg on entry edge; done=1 for exactly one cycle; then return to IDLE.
  - done and ct are driven from registers.
- Latency: a start sampled at edge E0 gives RUN for 11 edges (E1..E11). done is high in the cycle following E12, i.e. 12 clocks from start to done.
  - Next start may be accepted in the cycle after done (IDLE). Throughput is 1 block per 13 cycles.
- start while busy or in DONE is ignored, not queued. key/msg changes during RUN have no effect.
- start held high continuously: a new encryption begins each time IDLE is reached. Back-to-back blocks each produce their own done pulse.
- All arithmetic is GF(2^8) byte-wise. No overflow conditions exist. rnd is 4 bits and ranges 0..NR.

Decomposition:
- Shared package aes_pkg:
  - S-box constant array and Rcon constant array.
  - Function xtime and a fsm_t enum {IDLE, RUN, DONE}.
  - Localparams NR=10, DW=128.
- One sub-module, aes_round_dp: purely combinational round logic plus key-expansion step.
  - Inputs: x, rk, rnd.
  - Outputs: z, next_rk.
  - It reuses the existing SubBytes/ShiftRows/MixColumns/AddRoundKey blocks with a runtime mux on rnd, and a key-expansion step with an Rcon lookup.
- The sequencer holds only the FSM, counter and registers.

Test Plan:
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, msg=3243f6a8885a308d313198a2e0370734, start for 1 cycle -> done pulse exactly 12 cycles later; ct=3925841d02dc09fbdc118597196a0b32; busy high for 11 cycles.
- FIPS-197 App. C.1: key=000102030405060708090a0b0c0d0e0f, msg=00112233445566778899aabbccddeeff -> ct=69c4e0d86a7b0430d8cdb78070b4c55a; ct still holds this value 20 cycles later with start=0.
- start pulsed at cycles 3 and 7 after the first accept, with different key/msg -> ignored; ct equals the first vector's result; only one done pulse.
- start held high with the App. B then App. C.1 vectors applied at the IDLE acceptance points -> two done pulses 13 cycles apart with the correct ct each.
- rst=0 asserted for 1 cycle at RUN round 5 -> next cycle ready=1, busy=0, ct=0; no done pulse; a subsequent App. B run gives the correct ct.
- Internal probe during App. B: rk_reg after round 1 = a0fafe1788542cb123a339392a6c7605; after round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 constants, GF(2^8) helper and FSM encoding.
// Revision    : 1.0
// ============================================================================
package aes_pkg;

    localparam int NR = 10;
    localparam int DW = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] c_sbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry i is the constant used to derive round key i+1 from round key i.
    localparam logic [7:0] c_rcon [NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_dp.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_dp
// Description : Combinational AES-128 round with runtime round selection and
//               one key-expansion step.
// Revision    : 1.0
// ============================================================================
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] rk,
    input  logic [3:0]    rnd,
    output logic [DW-1:0] z,
    output logic [DW-1:0] next_rk
);

    localparam logic [3:0] c_last_rnd = 4'(NR);

    logic [7:0]    w_sb [16];
    logic [7:0]    w_sr [16];
    logic [DW-1:0] w_sr_v;
    logic [DW-1:0] w_mc_v;
    logic [31:0]   w_rot;
    logic [31:0]   w_sub_word;
    logic [7:0]    w_rcon;
    logic [31:0]   w_nk0;
    logic [31:0]   w_nk1;
    logic [31:0]   w_nk2;
    logic [31:0]   w_nk3;

    // Byte i sits at row i%4, column i/4; ShiftRows rotates row r left by r.
    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_byte
        localparam int c_row = gi % 4;
        localparam int c_col = gi / 4;
        assign w_sb[gi] = c_sbox[x[DW-1-8*gi -: 8]];
        assign w_sr[gi] = w_sb[4*((c_col + c_row) % 4) + c_row];
        assign w_sr_v[DW-1-8*gi -: 8] = w_sr[gi];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
        logic [7:0] w_a0;
        logic [7:0] w_a1;
        logic [7:0] w_a2;
        logic [7:0] w_a3;
        assign w_a0 = w_sr[4*gi];
        assign w_a1 = w_sr[4*gi+1];
        assign w_a2 = w_sr[4*gi+2];
        assign w_a3 = w_sr[4*gi+3];
        assign w_mc_v[DW-1-32*gi  -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mc_v[DW-9-32*gi  -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign w_mc_v[DW-17-32*gi -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign w_mc_v[DW-25-32*gi -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    always_comb begin
        if (rnd == 4'd0) begin
            z = x ^ rk;
        end else if (rnd == c_last_rnd) begin
            z = w_sr_v ^ rk;
        end else begin
            z = w_mc_v ^ rk;
        end
    end

    assign w_rot = {rk[23:0], rk[31:24]};

    for (gi = 0; gi < 4; gi++) begin : g_sub_word
        assign w_sub_word[31-8*gi -: 8] = c_sbox[w_rot[31-8*gi -: 8]];
    end

    // Past the last round there is no further key to derive.
    always_comb begin
        w_rcon = 8'h00;
        if (rnd < c_last_rnd) begin
            w_rcon = c_rcon[rnd];
        end
    end

    assign w_nk0   = rk[127:96] ^ w_sub_word ^ {w_rcon, 24'h000000};
    assign w_nk1   = rk[95:64]  ^ w_nk0;
    assign w_nk2   = rk[63:32]  ^ w_nk1;
    assign w_nk3   = rk[31:0]   ^ w_nk2;
    assign next_rk = {w_nk0, w_nk1, w_nk2, w_nk3};

endmodule
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_sequencer
// Description : Iterative AES-128 encryption controller, one round per clock.
// Revision    : 1.0
// ============================================================================
module aes_round_sequencer #(
    parameter int NR = 10,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] key,
    input  logic [DW-1:0] msg,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] ct
);

    import aes_pkg::*;

    if (NR != 10 || DW != 128) begin : g_bad_cfg
        $error("aes_round_sequencer supports only NR=10 and DW=128");
    end

    localparam logic [3:0] c_last_rnd = 4'(NR);

    fsm_t          r_state;
    fsm_t          w_next;
    logic [3:0]    r_rnd;
    logic [DW-1:0] r_x;
    logic [DW-1:0] r_rk;
    logic [DW-1:0] r_ct;
    logic          r_done;
    logic [DW-1:0] w_z;
    logic [DW-1:0] w_next_rk;

    aes_round_dp u_round_dp (
        .x       (r_x),
        .rk      (r_rk),
        .rnd     (r_rnd),
        .z       (w_z),
        .next_rk (w_next_rk)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (r_rnd == c_last_rnd) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (r_state)
            IDLE:    ready = 1'b1;
            RUN:     busy  = 1'b1;
            default: ;
        endcase
    end

    // The round key is frozen on the last round so it keeps round key NR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rnd  <= 4'd0;
            r_x    <= '0;
            r_rk   <= '0;
            r_ct   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_rnd <= 4'd0;
                    if (start) begin
                        r_x  <= msg;
                        r_rk <= key;
                    end
                end
                RUN: begin
                    r_x <= w_z;
                    if (r_rnd != c_last_rnd) begin
                        r_rk  <= w_next_rk;
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                DONE: begin
                    r_ct   <= r_x;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;
    assign ct   = r_ct;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_sequencer
// Description : Scoreboard bench with a behavioural AES-128 reference model.
// Revision    : 1.0
// ============================================================================
module tb_aes_round_sequencer;

    localparam logic [127:0] c_kb  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_mb  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_cb  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_kc  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_mc  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_cc  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_rk1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] msg;
    logic         ready;
    logic         busy;
    logic         done;
    logic [127:0] ct;

    aes_round_sequencer #(.NR(10), .DW(128)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .key   (key),
        .msg   (msg),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .ct    (ct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_done   = 0;

    logic [127:0] exp_q[$];
    int           acc_q[$];
    int           done_cyc_q[$];
    logic [7:0]   sb_tab [256];

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout, required event within bound", name);
    endfunction

    // ---------------- reference model: AES-128 from first principles ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] m);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = m[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            done_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 ct=%h, required no pending block", ct);
            end else begin
                chk("ct", ct, exp_q.pop_front());
                chk("latency_edge", 128'(cyc), 128'(acc_q.pop_front() + 12));
            end
        end
        if (rst === 1'b0) begin
            exp_q.delete();
            acc_q.delete();
        end else if (ready === 1'b1 && start === 1'b1) begin
            exp_q.push_back(aes_enc(key, msg));
            acc_q.push_back(cyc + 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        if (ready !== 1'b1) fail_now(name);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        if (done !== 1'b1) fail_now(name);
    endtask

    task automatic launch(input logic [127:0] k, input logic [127:0] m);
        key = k; msg = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_app_b();
        int busy_n;
        wait_ready("appb_ready");
        launch(c_kb, c_mb);
        busy_n = int'(busy);
        for (int i = 1; i <= 13; i++) begin
            tick();
            busy_n += int'(busy);
            if (i == 1)  chk("rk_round1", dut.r_rk, c_rk1);
            if (i == 10) chk("rk_round10", dut.r_rk, c_rk10);
            if (i == 12) chk("appb_done_at_edge12", 128'(done), 128'(1));
            if (i == 12) chk("appb_ct", ct, c_cb);
        end
        chk("appb_busy_cycles", 128'(busy_n), 128'(11));
    endtask

    initial begin
        int nd;
        int d0;
        for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));
        rst = 1'b0; start = 1'b0; key = '0; msg = '0;
        repeat (3) tick();
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_busy",  128'(busy),  128'(0));
        chk("rst_done",  128'(done),  128'(0));
        chk("rst_ct",    ct,          128'(0));
        rst = 1'b1;
        tick();

        run_app_b();

        // App C.1 with ciphertext hold
        wait_ready("appc_ready");
        launch(c_kc, c_mc);
        wait_done("appc_done");
        chk("appc_ct", ct, c_cc);
        repeat (20) tick();
        chk("appc_ct_hold", ct, c_cc);

        // starts during RUN are ignored
        wait_ready("ign_ready");
        nd = n_done;
        launch(c_kb, c_mb);
        repeat (2) tick();
        launch(c_kc, c_mc);
        repeat (3) tick();
        launch({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        wait_done("ign_done");
        chk("ign_ct", ct, c_cb);
        repeat (3) tick();
        chk("ign_one_done", 128'(n_done - nd), 128'(1));

        // start held high: back-to-back blocks
        wait_ready("hh_ready");
        d0 = done_cyc_q.size();
        key = c_kb; msg = c_mb; start = 1'b1;
        tick();
        key = c_kc; msg = c_mc;
        wait_ready("hh_second_accept");
        tick();
        start = 1'b0;
        wait_done("hh_done2");
        chk("hh_ct2", ct, c_cc);
        tick();
        if (done_cyc_q.size() >= d0 + 2)
            chk("hh_spacing", 128'(done_cyc_q[d0+1] - done_cyc_q[d0]), 128'(13));
        else
            fail_now("hh_two_dones");

        // reset in RUN round 5
        wait_ready("rr_ready");
        launch(c_kb, c_mb);
        repeat (5) tick();
        chk("rr_rnd5", 128'(dut.r_rnd), 128'(5));
        nd = n_done;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rr_ready", 128'(ready), 128'(1));
        chk("rr_busy",  128'(busy),  128'(0));
        chk("rr_ct",    ct,          128'(0));
        repeat (20) tick();
        chk("rr_no_done", 128'(n_done), 128'(nd));
        run_app_b();

        // randomized blocks with junk on the inputs while running
        for (int b = 0; b < 8; b++) begin
            wait_ready("rnd_ready");
            launch({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            for (int j = 0; j < 9; j++) begin
                key   = {$urandom, $urandom, $urandom, $urandom};
                msg   = {$urandom, $urandom, $urandom, $urandom};
                start = 1'($urandom_range(0, 1));
                tick();
            end
            start = 1'b0;
            wait_done("rnd_done");
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (4) tick();
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
